// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG image-buffer writer.
// No logic of its own; imported by the packer and the writer top.
package jpeg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_FLUSH,
      ST_DONE
   } buf_state_e;

   localparam int LINE_BYTES     = 16;
   localparam int WORDS_PER_LINE = 4;

   // One nibble of byte enables per written 32-bit lane, lane 0 lowest.
   function automatic logic [15:0] byte_en_for_words(input logic [2:0] n);
      logic [15:0] m;
      m = '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
         if (3'(k) < n) m[4*k +: 4] = 4'hF;
      end
      return m;
   endfunction

endpackage

// File: rtl/jpeg_line_packer.sv
// Packs 32-bit words into 128-bit lines; a full-line write strobes 1 cycle after lane 3, and a partial write is driven during flush.
// Never stalls the source: it accepts every word the top qualifies with accept_i.
module jpeg_line_packer
   import jpeg_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                clear_i,
   input  logic                accept_i,
   input  logic [31:0]         data_i,
   input  logic                flush_i,
   output logic [ADDR_W-3:0]   word_cnt_o,
   output logic                full_o,
   output logic                wr_en_o,
   output logic [ADDR_W-5:0]   wr_addr_o,
   output logic [127:0]        wr_data_o,
   output logic [15:0]         wr_byte_en_o
);

   localparam int WC_W = ADDR_W - 2;

   logic [3:0][31:0]  lane_q, lane_d;
   logic [WC_W-1:0]   wc_q, wc_d;
   logic              full_q, full_d;
   logic              pend_q, pend_d;
   logic [127:0]      fdata_q, fdata_d;
   logic [ADDR_W-5:0] faddr_q, faddr_d;
   logic [127:0]      pdata;

   always_comb begin
      lane_d  = lane_q;
      wc_d    = wc_q;
      full_d  = full_q;
      pend_d  = 1'b0;
      fdata_d = fdata_q;
      faddr_d = faddr_q;
      if (clear_i) begin
         lane_d = '0;
         wc_d   = '0;
         full_d = 1'b0;
      end else if (accept_i) begin
         lane_d[wc_q[1:0]] = data_i;
         wc_d = wc_q + 1'b1;
         if (&wc_q) full_d = 1'b1;
         // Snapshot the completed line so the next word can reuse lane 0 immediately.
         if (wc_q[1:0] == 2'd3) begin
            pend_d  = 1'b1;
            fdata_d = {data_i, lane_q[2:0]};
            faddr_d = wc_q[WC_W-1:2];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lane_q  <= '0;
         wc_q    <= '0;
         full_q  <= 1'b0;
         pend_q  <= 1'b0;
         fdata_q <= '0;
         faddr_q <= '0;
      end else begin
         lane_q  <= lane_d;
         wc_q    <= wc_d;
         full_q  <= full_d;
         pend_q  <= pend_d;
         fdata_q <= fdata_d;
         faddr_q <= faddr_d;
      end
   end

   always_comb begin
      pdata = '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
         if (2'(k) < wc_q[1:0]) pdata[32*k +: 32] = lane_q[k];
      end
   end

   always_comb begin
      wr_en_o      = 1'b0;
      wr_addr_o    = '0;
      wr_data_o    = '0;
      wr_byte_en_o = '0;
      if (pend_q) begin
         wr_en_o      = 1'b1;
         wr_addr_o    = faddr_q;
         wr_data_o    = fdata_q;
         wr_byte_en_o = 16'hFFFF;
      end else if (flush_i && (wc_q[1:0] != 2'd0)) begin
         wr_en_o      = 1'b1;
         wr_addr_o    = wc_q[WC_W-1:2];
         wr_data_o    = pdata;
         wr_byte_en_o = byte_en_for_words({1'b0, wc_q[1:0]});
      end
   end

   assign word_cnt_o = wc_q;
   assign full_o     = full_q;

endmodule

// File: rtl/jpeg_buffer_writer.sv
// Writes encoder words into the image buffer as 16-byte lines and reports final size/overflow.
// Full line written 1 cycle after its 4th word; no backpressure, words past capacity are dropped.
module jpeg_buffer_writer
   import jpeg_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int LINE_BYTES = 16
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start_in,
   input  logic [31:0]         data_in,
   input  logic                data_valid_in,
   input  logic                image_valid_in,
   output logic                wr_en_out,
   output logic [ADDR_W-5:0]   wr_addr_out,
   output logic [127:0]        wr_data_out,
   output logic [15:0]         wr_byte_en_out,
   output logic [ADDR_W:0]     size_out,
   output logic                done_out,
   output logic                overflow_out,
   output logic                busy_out
);

   localparam int BYTES_PER_WORD = LINE_BYTES / WORDS_PER_LINE;

   buf_state_e        state_q, state_d;
   logic              iv_q;
   logic              ovf_q, ovf_d;
   logic [ADDR_W:0]   size_q, size_d;
   logic              accept, drop, iv_rise;
   logic [ADDR_W-3:0] word_cnt;
   logic              full;

   assign iv_rise = image_valid_in & ~iv_q;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         ST_IDLE: ;
         ST_FILL: begin
            accept = data_valid_in & ~full;
            drop   = data_valid_in & full;
            if (iv_rise) state_d = ST_FLUSH;
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  ;
         default:  state_d = ST_IDLE;
      endcase
      if (start_in) begin
         state_d = ST_FILL;
         accept  = 1'b0;
         drop    = 1'b0;
      end
   end

   always_comb begin
      ovf_d  = start_in ? 1'b0 : (ovf_q | drop);
      size_d = size_q;
      if (start_in) begin
         size_d = '0;
      end else if (state_q == ST_FLUSH) begin
         // Counter wraps to 0 when the buffer is exactly full, so use the full flag.
         size_d = full ? ((ADDR_W+1)'(1) << ADDR_W)
                       : (ADDR_W+1)'(word_cnt) * (ADDR_W+1)'(BYTES_PER_WORD);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         iv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         iv_q    <= image_valid_in;
         ovf_q   <= ovf_d;
         size_q  <= size_d;
      end
   end

   jpeg_line_packer #(
      .ADDR_W (ADDR_W)
   ) u_packer (
      .clk          (clk),
      .resetn       (resetn),
      .clear_i      (start_in),
      .accept_i     (accept),
      .data_i       (data_in),
      .flush_i      (state_q == ST_FLUSH),
      .word_cnt_o   (word_cnt),
      .full_o       (full),
      .wr_en_o      (wr_en_out),
      .wr_addr_o    (wr_addr_out),
      .wr_data_o    (wr_data_out),
      .wr_byte_en_o (wr_byte_en_out)
   );

   assign size_out     = size_q;
   assign done_out     = (state_q == ST_DONE);
   assign overflow_out = ovf_q;
   assign busy_out     = (state_q == ST_FILL) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_jpeg_buffer_writer.sv
// Bench for jpeg_buffer_writer with a 64-byte (4-line) buffer: directed cases plus random images.
module tb_jpeg_buffer_writer;

   localparam int AW   = 6;
   localparam int CAPW = 1 << (AW - 2);

   logic            clk = 1'b0;
   logic            resetn;
   logic            start_in;
   logic [31:0]     data_in;
   logic            data_valid_in;
   logic            image_valid_in;
   logic            wr_en_out;
   logic [AW-5:0]   wr_addr_out;
   logic [127:0]    wr_data_out;
   logic [15:0]     wr_byte_en_out;
   logic [AW:0]     size_out;
   logic            done_out;
   logic            overflow_out;
   logic            busy_out;

   always #5 clk = ~clk;

   jpeg_buffer_writer #(.ADDR_W(AW), .LINE_BYTES(16)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .start_in       (start_in),
      .data_in        (data_in),
      .data_valid_in  (data_valid_in),
      .image_valid_in (image_valid_in),
      .wr_en_out      (wr_en_out),
      .wr_addr_out    (wr_addr_out),
      .wr_data_out    (wr_data_out),
      .wr_byte_en_out (wr_byte_en_out),
      .size_out       (size_out),
      .done_out       (done_out),
      .overflow_out   (overflow_out),
      .busy_out       (busy_out)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 collecting, 2 flushing, 3 finished.
   int          m_phase;
   logic [31:0] m_words[$];
   bit          m_ovf;
   int          m_size;
   bit          m_iv_prev;
   bit          e_en;
   int          e_addr;
   logic [127:0] e_data;
   logic [15:0] e_be;

   task automatic expect_line(input int line, input int cnt);
      e_en   = 1'b1;
      e_addr = line;
      e_data = '0;
      e_be   = '0;
      for (int k = 0; k < cnt; k++) begin
         e_data[32*k +: 32] = m_words[line*4 + k];
         e_be[4*k +: 4]     = 4'hF;
      end
   endtask

   task automatic model_reset();
      m_phase   = 0;
      m_words.delete();
      m_ovf     = 1'b0;
      m_size    = 0;
      m_iv_prev = 1'b0;
      e_en      = 1'b0;
   endtask

   task automatic model_edge(input bit st, input bit dv, input logic [31:0] d, input bit iv);
      int n;
      e_en = 1'b0;
      if (st) begin
         m_phase = 1;
         m_words.delete();
         m_ovf  = 1'b0;
         m_size = 0;
      end else begin
         case (m_phase)
            1: begin
               if (dv) begin
                  if (m_words.size() < CAPW) begin
                     m_words.push_back(d);
                     n = m_words.size();
                     if (n % 4 == 0) expect_line(n/4 - 1, 4);
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
               if (iv && !m_iv_prev) begin
                  m_phase = 2;
                  n = m_words.size();
                  if (n % 4 != 0) expect_line(n/4, n % 4);
               end
            end
            2: begin
               m_phase = 3;
               m_size  = m_words.size() * 4;
            end
            default: ;
         endcase
      end
      m_iv_prev = iv;
   endtask

   task automatic check_outputs();
      chk_val("wr_en", wr_en_out, e_en);
      if (e_en) begin
         chk_val("wr_addr", wr_addr_out, e_addr);
         chk_val("wr_data", wr_data_out, e_data);
         chk_val("wr_byte_en", wr_byte_en_out, e_be);
      end
      chk_val("done", done_out, m_phase == 3);
      chk_val("busy", busy_out, (m_phase == 1) || (m_phase == 2));
      chk_val("overflow", overflow_out, m_ovf);
      chk_val("size", size_out, m_size);
   endtask

   task automatic step(input bit st, input bit dv, input logic [31:0] d, input bit iv);
      start_in       = st;
      data_valid_in  = dv;
      data_in        = d;
      image_valid_in = iv;
      @(posedge clk);
      model_edge(st, dv, d, iv);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n, input bit iv);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, iv);
   endtask

   function automatic logic [31:0] seq_word(input int i);
      return 32'h03020100 + 32'(i) * 32'h04040404;
   endfunction

   initial begin
      resetn = 1'b0; start_in = 1'b0; data_in = '0;
      data_valid_in = 1'b0; image_valid_in = 1'b0;
      model_reset();
      #12;
      check_outputs();
      @(negedge clk);
      resetn = 1'b1;

      // Two full lines, flush has nothing left to write.
      step(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, seq_word(i), 0);
      step(0, 0, 0, 1);
      idle(2, 1);
      chk_val("t1_size", size_out, 32);
      chk_val("t1_done", done_out, 1'b1);

      // Fifth word coincides with the image_valid edge.
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, seq_word(i), i == 4);
      idle(2, 1);
      chk_val("t2_size", size_out, 20);

      // Overflow: 20 words into a 16-word buffer.
      step(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, $urandom, 0);
      step(0, 0, 0, 1);
      idle(2, 1);
      chk_val("t3_ovf", overflow_out, 1'b1);
      chk_val("t3_size", size_out, 64);

      // Restart mid-line: partial line is discarded, next word goes to lane 0 of line 0.
      idle(1, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, $urandom, 0);
      step(1, 0, 0, 0);
      chk_val("t4_ovf_clr", overflow_out, 1'b0);
      chk_val("t4_done_clr", done_out, 1'b0);
      for (int i = 0; i < 4; i++) step(0, 1, seq_word(i + 20), 0);
      chk_val("t4_line0_lane0", wr_data_out[31:0], seq_word(20));

      // Words and a second image_valid edge in DONE change nothing.
      step(0, 0, 0, 1);
      idle(1, 1);
      idle(1, 0);
      for (int i = 0; i < 3; i++) step(0, 1, $urandom, i == 1);
      chk_val("t6_size", size_out, 16);

      // Async reset while a full-line write is on the bus.
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, seq_word(i), 0);
      data_in = seq_word(3); data_valid_in = 1'b1;
      @(posedge clk);
      model_edge(0, 1, seq_word(3), 0);
      #1;
      chk_val("t5_pre_wr_en", wr_en_out, 1'b1);
      resetn = 1'b0;
      #1;
      model_reset();
      chk_val("t5_rst_wr_en", wr_en_out, 1'b0);
      chk_val("t5_rst_addr", wr_addr_out, 0);
      chk_val("t5_rst_data", wr_data_out, 0);
      chk_val("t5_rst_be", wr_byte_en_out, 0);
      chk_val("t5_rst_busy", busy_out, 1'b0);
      chk_val("t5_rst_size", size_out, 0);
      @(negedge clk);
      data_valid_in = 1'b0;
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0);
      step(0, 0, 0, 1);
      idle(1, 0);

      // Random images.
      for (int img = 0; img < 30; img++) begin
         int  nw;
         bit  sent;
         step(1, 0, 0, 0);
         nw   = $urandom_range(0, 22);
         sent = 1'b0;
         for (int i = 0; i < nw; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1, 0);
            if ((i == nw - 1) && ($urandom_range(0, 1) == 1)) begin
               step(0, 1, $urandom, 1);
               sent = 1'b1;
            end else begin
               step(0, 1, $urandom, 0);
            end
         end
         if ($urandom_range(0, 9) == 0) continue;
         if (!sent) step(0, 0, 0, 1);
         for (int i = 0; i < 4; i++) step(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
         idle(1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
